// File: rtl/alu_seq_shifter_pkg.sv
// Shared constants and types for the sequential shifter: FuncCode encodings,
// FSM state type and a decode helper.
package alu_seq_shifter_pkg;

    localparam logic [3:0] FUNC_LSL = 4'b1010;
    localparam logic [3:0] FUNC_LSR = 4'b1011;
    localparam logic [3:0] FUNC_ASL = 4'b1100;
    localparam logic [3:0] FUNC_ASR = 4'b1101;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    function automatic logic is_shift(input logic [3:0] f);
        return (f == FUNC_LSL) || (f == FUNC_LSR) || (f == FUNC_ASL) || (f == FUNC_ASR);
    endfunction

endpackage

// File: rtl/alu_seq_shifter_shift_step.sv
// Combinational single-bit shift step; with ALU_SHIFT_OVERFLOW_EN defined it
// also reports whether this step overflows.
module shift_step
    import alu_seq_shifter_pkg::*;
#(
    parameter int unsigned data_width = 16
) (
    input  logic [data_width-1:0] din,
    input  logic [3:0]            func,
    output logic [data_width-1:0] dout
`ifdef ALU_SHIFT_OVERFLOW_EN
    ,
    output logic                  ovf
`endif
);

    always_comb begin
        dout = din;
        case (func)
            FUNC_LSL, FUNC_ASL: dout = {din[data_width-2:0], 1'b0};
            FUNC_LSR:           dout = {1'b0, din[data_width-1:1]};
            FUNC_ASR:           dout = {din[data_width-1], din[data_width-1:1]};
            default:            dout = din;
        endcase
    end

`ifdef ALU_SHIFT_OVERFLOW_EN
    // Logical left overflows on a lost 1; arithmetic left when the sign flips.
    always_comb begin
        ovf = 1'b0;
        case (func)
            FUNC_LSL: ovf = din[data_width-1];
            FUNC_ASL: ovf = din[data_width-1] ^ din[data_width-2];
            default:  ovf = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/alu_seq_shifter.sv
// Sequential one-bit-per-cycle shifter with valid/ready handshakes.
// Optional sticky overflow flag enabled by defining ALU_SHIFT_OVERFLOW_EN.
module alu_seq_shifter
    import alu_seq_shifter_pkg::*;
#(
    parameter int unsigned data_width = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [data_width-1:0] A,
    input  logic [data_width-1:0] B,
    input  logic [3:0]            FuncCode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] C,
    output logic                  OverflowFlag
);

    localparam int unsigned SW = $clog2(data_width);

    state_t                state;
    logic [data_width-1:0] work;
    logic [data_width-1:0] step_out;
    logic [3:0]            func_q;
    logic [SW-1:0]         cnt;
    logic [SW-1:0]         amount;
    logic                  unused_b_hi;

    assign amount      = B[SW-1:0];
    assign unused_b_hi = ^B[data_width-1:SW];

`ifdef ALU_SHIFT_OVERFLOW_EN
    logic step_ovf;
    logic ovf_acc;

    shift_step #(.data_width(data_width)) u_step (
        .din  (work),
        .func (func_q),
        .dout (step_out),
        .ovf  (step_ovf)
    );
`else
    shift_step #(.data_width(data_width)) u_step (
        .din  (work),
        .func (func_q),
        .dout (step_out)
    );

    assign OverflowFlag = 1'b0;
`endif

    // C is only written on entry to DONE so it holds the last result in IDLE/SHIFT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            C         <= '0;
            work      <= '0;
            func_q    <= '0;
            cnt       <= '0;
`ifdef ALU_SHIFT_OVERFLOW_EN
            ovf_acc      <= 1'b0;
            OverflowFlag <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= A;
                        func_q   <= FuncCode;
                        cnt      <= amount;
                        in_ready <= 1'b0;
`ifdef ALU_SHIFT_OVERFLOW_EN
                        ovf_acc  <= 1'b0;
`endif
                        if (is_shift(FuncCode) && (amount != '0)) begin
                            state <= SHIFT;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            C         <= is_shift(FuncCode) ? A : '0;
`ifdef ALU_SHIFT_OVERFLOW_EN
                            OverflowFlag <= 1'b0;
`endif
                        end
                    end
                end
                SHIFT: begin
                    work <= step_out;
                    cnt  <= cnt - SW'(1);
`ifdef ALU_SHIFT_OVERFLOW_EN
                    ovf_acc <= ovf_acc | step_ovf;
`endif
                    if (cnt == SW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        C         <= step_out;
`ifdef ALU_SHIFT_OVERFLOW_EN
                        OverflowFlag <= ovf_acc | step_ovf;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_shifter.sv
// Self-checking bench for alu_seq_shifter: directed vectors, randomized
// operations against an arithmetic reference model, reset and back-pressure.
module tb_alu_seq_shifter;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   FuncCode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] C;
    logic         OverflowFlag;

    int checks;
    int failures;

    alu_seq_shifter #(.data_width(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .A            (A),
        .B            (B),
        .FuncCode     (FuncCode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .C            (C),
        .OverflowFlag (OverflowFlag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: whole-operation result from plain shift arithmetic.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [3:0] f, output logic [W-1:0] c,
                                  output logic v, output int lat);
        int   n;
        int   top;
        logic ovf;
        n   = int'(b) % W;
        ovf = 1'b0;
        lat = n + 1;
        case (f)
            4'b1010: begin
                c   = W'(a << n);
                ovf = (n > 0) && ((int'(a) >> (W - n)) != 0);
            end
            4'b1011: c = a >> n;
            4'b1100: begin
                c   = W'(a << n);
                top = int'(a) >> (W - 1 - n);
                ovf = (top != 0) && (top != ((1 << (n + 1)) - 1));
            end
            4'b1101: c = W'($signed(a) >>> n);
            default: begin
                c   = '0;
                lat = 1;
            end
        endcase
`ifdef ALU_SHIFT_OVERFLOW_EN
        v = ovf;
`else
        v = 1'b0;
`endif
    endfunction

    // Issue one request, scramble inputs afterwards, wait for the result and accept it.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f,
                         output logic [W-1:0] c, output logic v, output int lat,
                         output logic busy_in_done, output logic ok);
        int guard;
        ok    = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) ok = 1'b0;
        in_valid = 1'b1;
        A = a;
        B = b;
        FuncCode = f;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        FuncCode = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) ok = 1'b0;
        c = C;
        v = OverflowFlag;
        busy_in_done = in_ready;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0;
        B = '0;
        FuncCode = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || C !== '0 || OverflowFlag !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b C=%h ovf=%b, want 1 0 0000 0",
                     in_ready, out_valid, C, OverflowFlag);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        logic [W-1:0] ta [7];
        logic [W-1:0] tb [7];
        logic [3:0]   tf [7];
        logic [W-1:0] tc [7];
        logic         tv [7];
        int           tl [7];
        logic [W-1:0] c;
        logic         v;
        logic         busy;
        logic         ok;
        logic         want_v;
        int           lat;
        ta = '{16'h8001, 16'h8000, 16'h8000, 16'h4000, 16'h4000, 16'h1234, 16'h0001};
        tb = '{16'd3,    16'd15,   16'd15,   16'd1,    16'd0,    16'hFFFF, 16'h00FF};
        tf = '{4'b1010,  4'b1101,  4'b1011,  4'b1100,  4'b1100,  4'b0000,  4'b1010};
        tc = '{16'h0008, 16'hFFFF, 16'h0001, 16'h8000, 16'h4000, 16'h0000, 16'h8000};
        tv = '{1'b1,     1'b0,     1'b0,     1'b1,     1'b0,     1'b0,     1'b0};
        tl = '{4,        16,       16,       2,        1,        1,        16};
        for (int i = 0; i < 7; i++) begin
`ifdef ALU_SHIFT_OVERFLOW_EN
            want_v = tv[i];
`else
            want_v = 1'b0;
`endif
            do_op(ta[i], tb[i], tf[i], c, v, lat, busy, ok);
            checks++;
            if (!ok || c !== tc[i] || v !== want_v || lat != tl[i] || busy !== 1'b0) begin
                failures++;
                $display("FAIL vector%0d: ok=%b C=%h ovf=%b lat=%0d in_ready=%b, want C=%h ovf=%b lat=%0d in_ready=0",
                         i, ok, c, v, lat, busy, tc[i], want_v, tl[i]);
            end
            checks++;
            if (C !== tc[i] || out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL idle_hold%0d: C=%h out_valid=%b in_ready=%b, want C=%h 0 1",
                         i, C, out_valid, in_ready, tc[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   f;
        logic [W-1:0] c;
        logic [W-1:0] ec;
        logic         v;
        logic         ev;
        logic         busy;
        logic         ok;
        int           lat;
        int           el;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            if (i % 8 == 7) f = 4'($urandom);
            else            f = 4'(4'b1010 + $urandom_range(0, 3));
            model(a, b, f, ec, ev, el);
            do_op(a, b, f, c, v, lat, busy, ok);
            checks++;
            if (!ok || c !== ec || v !== ev || lat != el) begin
                failures++;
                $display("FAIL random%0d a=%h b=%h f=%b: ok=%b C=%h ovf=%b lat=%0d, want C=%h ovf=%b lat=%0d",
                         i, a, b, f, ok, c, v, lat, ec, ev, el);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        logic seen;
        in_valid = 1'b1;
        A = 16'hA5A5;
        B = 16'd8;
        FuncCode = 4'b1010;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || C !== '0 || OverflowFlag !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_shift: in_ready=%b out_valid=%b C=%h ovf=%b, want 1 0 0000 0",
                     in_ready, out_valid, C, OverflowFlag);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_discard: out_valid seen=%b, want 0", seen);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        logic         stable;
        int           guard;
        in_valid = 1'b1;
        A = 16'h00F0;
        B = 16'd2;
        FuncCode = 4'b1011;
        @(posedge clk); #1;
        guard = 0;
        while (!out_valid && guard < 20) begin
            A = W'($urandom);
            @(posedge clk); #1;
            guard++;
        end
        held = C;
        checks++;
        if (out_valid !== 1'b1 || held !== 16'h003C) begin
            failures++;
            $display("FAIL bp_result: out_valid=%b C=%h, want 1 003c", out_valid, held);
        end
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            A = W'($urandom);
            @(posedge clk); #1;
            if (C !== held || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold: stable=%b, want 1", stable);
        end
        A = 16'h8421;
        B = 16'd0;
        FuncCode = 4'b1101;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || C !== held) begin
            failures++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b C=%h, want 1 0 %h",
                     in_ready, out_valid, C, held);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || C !== 16'h8421 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back: out_valid=%b C=%h in_ready=%b, want 1 8421 0",
                     out_valid, C, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_vectors();
        test_random();
        test_reset_mid_shift();
        test_backpressure();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
